// File: rtl/sfifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sfifo_param
// Description : Parametrised single-clock FIFO with same-cycle-exact flags,
//               programmable almost-full/almost-empty thresholds, occupancy
//               count, overflow/underflow pulses and optional first-word-
//               fall-through read mode.
// Revision    : 1.0 - initial release
// ============================================================================
module sfifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4,
    parameter int FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     winc,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rinc,
    output logic [WIDTH-1:0]         rdata,
    output logic                     wfull,
    output logic                     rempty,
    output logic                     walmost_full,
    output logic                     ralmost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;

    // Thresholds pre-sized to the count width so comparisons stay width-exact.
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT  = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AFULL_CNT  = c_CNT_W'(AFULL_TH);
    localparam logic [c_CNT_W-1:0] c_AEMPTY_CNT = c_CNT_W'(AEMPTY_TH);
    localparam logic [c_ADDR_W:0]  c_PTR_ONE    = {{c_ADDR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_ADDR_W:0]   r_wptr;
    logic [c_ADDR_W:0]   r_rptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_wfull;
    logic                r_rempty;
    logic                r_afull;
    logic                r_aempty;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_wen;
    logic                w_ren;
    logic [c_CNT_W-1:0]  w_count_nxt;

    // Accepts are gated by the registered flags, which are exact every cycle.
    assign w_wen       = winc & ~r_wfull;
    assign w_ren       = rinc & ~r_rempty;
    assign w_count_nxt = r_count + {{c_ADDR_W{1'b0}}, w_wen}
                                 - {{c_ADDR_W{1'b0}}, w_ren};

    // Pointers, occupancy and all flags derive from the next count so the
    // flags reflect the access in the very next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_wfull     <= 1'b0;
            r_rempty    <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wen) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_ren) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            r_count     <= w_count_nxt;
            r_wfull     <= (w_count_nxt == c_DEPTH_CNT);
            r_rempty    <= (w_count_nxt == '0);
            r_afull     <= (w_count_nxt >= c_AFULL_CNT);
            r_aempty    <= (w_count_nxt <= c_AEMPTY_CNT);
            r_overflow  <= winc & r_wfull;
            r_underflow <= rinc & r_rempty;
        end
    end

    // Storage array is deliberately not reset; writes are blocked during reset.
    always_ff @(posedge clk) begin
        if (!rst && w_wen) begin
            r_mem[r_wptr[c_ADDR_W-1:0]] <= wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is visible combinationally whenever the FIFO is non-empty.
            assign rdata = r_mem[r_rptr[c_ADDR_W-1:0]];
        end else begin : g_std
            logic [WIDTH-1:0] r_rdata;

            // Registered read port: loads on an accepted read, holds otherwise.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata <= '0;
                end else if (w_ren) begin
                    r_rdata <= r_mem[r_rptr[c_ADDR_W-1:0]];
                end
            end

            assign rdata = r_rdata;
        end
    endgenerate

    assign wfull         = r_wfull;
    assign rempty        = r_rempty;
    assign walmost_full  = r_afull;
    assign ralmost_empty = r_aempty;
    assign count         = r_count;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sfifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfifo_param
// Description : Directed self-checking bench for sfifo_param, standard-read
//               instance (FWFT=0) plus a first-word-fall-through instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfifo_param;

    logic       clk;
    logic       rst;
    logic       winc;
    logic [7:0] wdata;
    logic       rinc;
    logic [7:0] rdata;
    logic       wfull;
    logic       rempty;
    logic       walmost_full;
    logic       ralmost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    logic       f_rst;
    logic       f_winc;
    logic [7:0] f_wdata;
    logic       f_rinc;
    logic [7:0] f_rdata;
    logic       f_wfull;
    logic       f_rempty;
    logic       f_walmost_full;
    logic       f_ralmost_empty;
    logic [4:0] f_count;
    logic       f_overflow;
    logic       f_underflow;

    int checks;
    int errors;

    sfifo_param #(.WIDTH(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(0)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .winc          (winc),
        .wdata         (wdata),
        .rinc          (rinc),
        .rdata         (rdata),
        .wfull         (wfull),
        .rempty        (rempty),
        .walmost_full  (walmost_full),
        .ralmost_empty (ralmost_empty),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    sfifo_param #(.WIDTH(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4), .FWFT(1)) u_dut_fwft (
        .clk           (clk),
        .rst           (f_rst),
        .winc          (f_winc),
        .wdata         (f_wdata),
        .rinc          (f_rinc),
        .rdata         (f_rdata),
        .wfull         (f_wfull),
        .rempty        (f_rempty),
        .walmost_full  (f_walmost_full),
        .ralmost_empty (f_ralmost_empty),
        .count         (f_count),
        .overflow      (f_overflow),
        .underflow     (f_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        winc = 1'b0;
        rinc = 1'b0;
        step();
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        winc  = 1'b1;
        rinc  = 1'b1;
        wdata = 8'hEE;
        step();
        step();
        checks++; if (count !== 5'd0)        begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (rempty !== 1'b1)       begin errors++; $display("FAIL reset_rempty got %b exp 1", rempty); end
        checks++; if (wfull !== 1'b0)        begin errors++; $display("FAIL reset_wfull got %b exp 0", wfull); end
        checks++; if (ralmost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b exp 1", ralmost_empty); end
        checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", walmost_full); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0)
            begin errors++; $display("FAIL reset_pulses got ovf=%b unf=%b exp 0 0", overflow, underflow); end
        checks++; if (rdata !== 8'h00)       begin errors++; $display("FAIL reset_rdata got %h exp 00", rdata); end
        rst  = 1'b0;
        winc = 1'b0;
        rinc = 1'b0;
        step();
        checks++; if (count !== 5'd0 || rempty !== 1'b1)
            begin errors++; $display("FAIL reset_idle got count=%0d rempty=%b exp 0 1", count, rempty); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            winc  = 1'b1;
            wdata = 8'(i);
            step();
            checks++; if (count !== 5'(i))
                begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i); end
            checks++; if (walmost_full !== (i >= 12))
                begin errors++; $display("FAIL fill_afull[%0d] got %b exp %b", i, walmost_full, (i >= 12)); end
            checks++; if (wfull !== (i == 16))
                begin errors++; $display("FAIL fill_wfull[%0d] got %b exp %b", i, wfull, (i == 16)); end
            checks++; if (rempty !== 1'b0)
                begin errors++; $display("FAIL fill_rempty[%0d] got %b exp 0", i, rempty); end
        end
        wdata = 8'hFF;
        step();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b exp 1", overflow); end
        checks++; if (count !== 5'd16)   begin errors++; $display("FAIL fill_ovf_count got %0d exp 16", count); end
        winc = 1'b0;
        step();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_pulse got %b exp 0", overflow); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            rinc = 1'b1;
            step();
            checks++; if (rdata !== 8'(i))
                begin errors++; $display("FAIL drain_rdata[%0d] got %h exp %h", i, rdata, 8'(i)); end
            checks++; if (count !== 5'(16 - i))
                begin errors++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, count, 16 - i); end
            checks++; if (ralmost_empty !== ((16 - i) <= 4))
                begin errors++; $display("FAIL drain_aempty[%0d] got %b exp %b", i, ralmost_empty, ((16 - i) <= 4)); end
            checks++; if (rempty !== (i == 16))
                begin errors++; $display("FAIL drain_rempty[%0d] got %b exp %b", i, rempty, (i == 16)); end
        end
        step();
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL drain_underflow got %b exp 1", underflow); end
        checks++; if (rdata !== 8'h10)    begin errors++; $display("FAIL drain_hold got %h exp 10", rdata); end
        checks++; if (count !== 5'd0)     begin errors++; $display("FAIL drain_unf_count got %0d exp 0", count); end
        rinc = 1'b0;
        step();
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL drain_unf_pulse got %b exp 0", underflow); end
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= 16; i++) begin
            winc  = 1'b1;
            wdata = 8'(8'h20 + i);
            step();
        end
        // Full: write rejected, read accepted.
        winc  = 1'b1;
        rinc  = 1'b1;
        wdata = 8'hAA;
        step();
        checks++; if (count !== 5'd15)    begin errors++; $display("FAIL simfull_count got %0d exp 15", count); end
        checks++; if (wfull !== 1'b0)     begin errors++; $display("FAIL simfull_wfull got %b exp 0", wfull); end
        checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL simfull_overflow got %b exp 1", overflow); end
        checks++; if (rdata !== 8'h21)    begin errors++; $display("FAIL simfull_rdata got %h exp 21", rdata); end
        winc = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            rinc = 1'b1;
            step();
            checks++; if (rdata !== 8'(8'h21 + i))
                begin errors++; $display("FAIL simdrain_rdata[%0d] got %h exp %h", i, rdata, 8'(8'h21 + i)); end
        end
        // Empty: read rejected, write accepted.
        winc  = 1'b1;
        rinc  = 1'b1;
        wdata = 8'h55;
        step();
        checks++; if (count !== 5'd1)     begin errors++; $display("FAIL simempty_count got %0d exp 1", count); end
        checks++; if (rempty !== 1'b0)    begin errors++; $display("FAIL simempty_rempty got %b exp 0", rempty); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL simempty_underflow got %b exp 1", underflow); end
        checks++; if (rdata !== 8'h30)    begin errors++; $display("FAIL simempty_rdata got %h exp 30", rdata); end
        rinc = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            wdata = 8'(8'h60 + i);
            step();
        end
        checks++; if (count !== 5'd8)     begin errors++; $display("FAIL simmid_pre got %0d exp 8", count); end
        // Mid-level: both accepted, count unchanged.
        rinc  = 1'b1;
        wdata = 8'h77;
        step();
        checks++; if (count !== 5'd8)     begin errors++; $display("FAIL simmid_count got %0d exp 8", count); end
        checks++; if (rdata !== 8'h55)    begin errors++; $display("FAIL simmid_rdata got %h exp 55", rdata); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0)
            begin errors++; $display("FAIL simmid_pulses got ovf=%b unf=%b exp 0 0", overflow, underflow); end
        winc = 1'b0;
        rinc = 1'b0;
        do_reset();
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        logic [7:0] last_rd;
        logic       w, r, exp_ov, exp_un;
        last_rd = 8'h00;
        for (int c = 0; c < 120; c++) begin
            w      = 1'($urandom_range(0, 1));
            r      = 1'($urandom_range(0, 1));
            winc   = w;
            rinc   = r;
            wdata  = 8'($urandom_range(0, 255));
            exp_ov = w && (q.size() == 16);
            exp_un = r && (q.size() == 0);
            if (r && q.size() != 0) last_rd = q.pop_front();
            if (w && !exp_ov) q.push_back(wdata);
            step();
            checks++; if (count !== 5'(q.size()))
                begin errors++; $display("FAIL wrap_count[%0d] got %0d exp %0d", c, count, q.size()); end
            checks++; if (rdata !== last_rd)
                begin errors++; $display("FAIL wrap_rdata[%0d] got %h exp %h", c, rdata, last_rd); end
            checks++; if (overflow !== exp_ov || underflow !== exp_un)
                begin errors++; $display("FAIL wrap_pulses[%0d] got %b%b exp %b%b", c, overflow, underflow, exp_ov, exp_un); end
            checks++; if (rempty !== (q.size() == 0) || wfull !== (q.size() == 16))
                begin errors++; $display("FAIL wrap_flags[%0d] got e=%b f=%b exp e=%b f=%b", c, rempty, wfull, (q.size() == 0), (q.size() == 16)); end
        end
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    task automatic test_fwft();
        f_rst  = 1'b1;
        f_winc = 1'b0;
        f_rinc = 1'b0;
        step();
        f_rst   = 1'b0;
        f_winc  = 1'b1;
        f_wdata = 8'hA5;
        step();
        f_winc = 1'b0;
        checks++; if (f_rempty !== 1'b0) begin errors++; $display("FAIL fwft_rempty got %b exp 0", f_rempty); end
        checks++; if (f_rdata !== 8'hA5) begin errors++; $display("FAIL fwft_rdata got %h exp a5", f_rdata); end
        checks++; if (f_count !== 5'd1)  begin errors++; $display("FAIL fwft_count got %0d exp 1", f_count); end
        step();
        checks++; if (f_rdata !== 8'hA5 || f_count !== 5'd1)
            begin errors++; $display("FAIL fwft_hold got %h/%0d exp a5/1", f_rdata, f_count); end
        f_rinc = 1'b1;
        step();
        f_rinc = 1'b0;
        checks++; if (f_rempty !== 1'b1 || f_count !== 5'd0)
            begin errors++; $display("FAIL fwft_pop got e=%b c=%0d exp 1 0", f_rempty, f_count); end
        checks++; if (f_underflow !== 1'b0) begin errors++; $display("FAIL fwft_unf got %b exp 0", f_underflow); end
        for (int i = 1; i <= 3; i++) begin
            f_winc  = 1'b1;
            f_wdata = 8'(8'h11 * i);
            step();
            checks++; if (f_rdata !== 8'h11)
                begin errors++; $display("FAIL fwft_head[%0d] got %h exp 11", i, f_rdata); end
        end
        f_rst = 1'b1;
        step();
        f_rst  = 1'b0;
        f_winc = 1'b0;
        checks++; if (f_count !== 5'd0 || f_rempty !== 1'b1)
            begin errors++; $display("FAIL fwft_rst got c=%0d e=%b exp 0 1", f_count, f_rempty); end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        winc    = 1'b0;
        rinc    = 1'b0;
        wdata   = 8'h00;
        f_rst   = 1'b1;
        f_winc  = 1'b0;
        f_rinc  = 1'b0;
        f_wdata = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_fwft();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
